dlf_mac_sequencer: RTL
======================

# dlf_mac_sequencer

Operand sequencer and result capture for the DLFloat16 multiply-accumulate datapath. It takes a stream of 16-bit words on a valid/ready handshake and pairs them into (a, b) operands. It issues each pair to the MAC with a one-cycle valid strobe and clears the accumulator at the start of each dot product. After the MAC pipeline drains, it captures the final accumulated value. It sits directly upstream of the MAC and replaces the free-running two-word register loader.

## Interface
Parameters:
- LEN_W, default 8: width of the vector-length field and pair counter.
- MAC_LAT, default 3: cycles from an op_valid pulse until its product is reflected in result_in. Legal range 1..15.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin a dot product of len pairs. Sampled only in IDLE.
- len, input, LEN_W: number of operand pairs. Sampled with start.
- in_data, input, 16: DLFloat16 operand word (1 sign, 6 exponent with bias 31, 9 mantissa).
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: sequencer accepts in_data this cycle.
- op_a, output, 16: MAC operand A.
- op_b, output, 16: MAC operand B.
- op_valid, output, 1: one-cycle strobe; op_a/op_b are valid this cycle.
- acc_clr, output, 1: one-cycle accumulator clear to the MAC.
- result_in, input, 16: accumulated value from the MAC.
- result, output, 16: captured dot-product result.
- result_valid, output, 1: one-cycle strobe; result updated.
- busy, output, 1: high in every state except IDLE.

## Operation
- States: IDLE, CLEAR, LOAD_A, LOAD_B, DRAIN.
- IDLE:
  - start=1 with len≠0: latch len, zero the pair counter, go to CLEAR.
  - start=1 with len=0: result←0x0000, result_valid pulses next cycle, stay in IDLE. acc_clr is not asserted.
- CLEAR: acc_clr=1 for exactly this one cycle, then go to LOAD_A.
- LOAD_A:
  - in_ready=1.
  - On in_valid: capture in_data into a_hold, go to LOAD_B.
- LOAD_B:
  - in_ready=1.
  - On in_valid: register op_a←a_hold, op_b←in_data, op_valid←1, and increment the pair counter.
  - If the pair counter was len−1, go to DRAIN (drain timer←0); otherwise go to LOAD_A.
- DRAIN:
  - in_ready=0.
  - The timer increments every cycle.
  - When the timer reaches MAC_LAT−1: result←result_in, result_valid←1, go to IDLE.
- in_ready is 0 in IDLE, CLEAR and DRAIN. in_data offered in those states is not consumed.
- start is ignored while busy=1.
- op_a and op_b hold their last values when op_valid=0.
- The pair counter is LEN_W bits wide and never wraps: the maximum len is 2^LEN_W−1.
- Reset mid-operation returns the block to IDLE immediately. No acc_clr, op_valid or result_valid pulse is produced by reset.
- Reset values:
  - in_ready=0, op_a=0x0000, op_b=0x0000, op_valid=0, acc_clr=0, result=0x0000, result_valid=0, busy=0.
  - Internal: a_hold=0, counter=0, timer=0.

## Timing
- All outputs are registered.
- acc_clr is high in the cycle after start is sampled.
- in_ready first rises one cycle after that.
- Each pair costs at least 2 cycles; back-to-back in_valid sustains one pair per 2 cycles.
- op_valid is high in the cycle after the B-word handshake.
- result_valid is high MAC_LAT cycles after the final op_valid, at the earliest. busy drops in the same cycle.
- The earliest new start is accepted in the cycle result_valid is high, because the state is IDLE.
- in_valid stalls insert idle cycles without loss: state, a_hold and the counter hold their values.

## Configuration
- DLF_SEQ_ZERO_SKIP_EN defined:
  - A pair where either operand has bits[14:0]==0 is counted but not issued. op_valid stays 0, and op_a/op_b keep their previous values.
  - The drain timer starts from the final pair regardless of whether it was issued.
- DLF_SEQ_ZERO_SKIP_EN undefined: every pair is issued.

## Test plan
- Reset asserted mid-LOAD_B:
  - Outputs return to their reset values asynchronously.
  - No op_valid is produced.
  - The next start with len=1 works normally.
- len=1, words 0x3E00 (1.0) then 0x4000 (2.0), MAC_LAT=3, model MAC driving result_in=0x4000:
  - One acc_clr pulse.
  - One op_valid with op_a=0x3E00, op_b=0x4000.
  - result_valid 3 cycles later with result=0x4000.
- len=3, in_valid toggling 1,0,1,0:
  - Exactly 3 op_valid pulses with the correct pairings.
  - in_ready=0 in DRAIN.
  - start pulsed during DRAIN is ignored.
- len=0 start:
  - result=0x0000 and result_valid pulse on the next cycle.
  - No acc_clr, no op_valid, busy stays 0.
- len=255 (LEN_W=8), continuous valid:
  - 255 op_valid pulses, 2 cycles apart.
  - DRAIN entered after the 255th pair; no counter wrap.
- With DLF_SEQ_ZERO_SKIP_EN, len=2, pairs (0x8000, 0x3E00) and (0x3E00, 0x3E00):
  - Only one op_valid (0x3E00, 0x3E00).
  - result_valid MAC_LAT cycles after the second pair.

Source files
------------

// File: rtl/dlf_mac_sequencer.sv
// dlf_mac_sequencer: pairs a 16-bit DLFloat16 word stream into (a, b) MAC operands,
// clears the accumulator per dot product and captures the result after the MAC drains.
// Build option DLF_SEQ_ZERO_SKIP_EN: pairs with a +/-0 operand are counted but not issued.
module dlf_mac_sequencer #(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      op_a,
  output logic [15:0]      op_b,
  output logic             op_valid,
  output logic             acc_clr,
  input  logic [15:0]      result_in,
  output logic [15:0]      result,
  output logic             result_valid,
  output logic             busy
);

  // Drain timer value at which the last product is visible on result_in.
  localparam logic [3:0] TMR_LAST = 4'(MAC_LAT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD_A, LOAD_B, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] pair_cnt;
  logic [3:0]       timer;
  logic [15:0]      a_hold;

  logic take_a, take_b, last_pair, zero_start, drain_done, issue;

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (len != '0)) state_nxt = CLEAR;
      CLEAR:   state_nxt = LOAD_A;
      LOAD_A:  if (take_a) state_nxt = LOAD_B;
      LOAD_B:  if (take_b) state_nxt = last_pair ? DRAIN : LOAD_A;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and event decode for the current state.
  always_comb begin
    take_a     = (state == LOAD_A) && in_valid;
    take_b     = (state == LOAD_B) && in_valid;
    last_pair  = (pair_cnt == len_q - LEN_W'(1));
    zero_start = (state == IDLE) && start && (len == '0);
    drain_done = (state == DRAIN) && (timer == TMR_LAST);
`ifdef DLF_SEQ_ZERO_SKIP_EN
    // A zero product cannot change the sum, so skip the MAC issue but keep counting.
    issue = take_b && (a_hold[14:0] != 15'd0) && (in_data[14:0] != 15'd0);
`else
    issue = take_b;
`endif
  end

  // Registered status strobes, decoded from the upcoming state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      acc_clr      <= 1'b0;
      op_valid     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      in_ready     <= (state_nxt == LOAD_A) || (state_nxt == LOAD_B);
      busy         <= (state_nxt != IDLE);
      acc_clr      <= (state_nxt == CLEAR);
      op_valid     <= issue;
      result_valid <= zero_start || drain_done;
    end
  end

  // Operand capture, pair counting, drain timing and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q    <= '0;
      pair_cnt <= '0;
      timer    <= 4'd0;
      a_hold   <= 16'h0000;
      op_a     <= 16'h0000;
      op_b     <= 16'h0000;
      result   <= 16'h0000;
    end else begin
      if ((state == IDLE) && start) begin
        len_q    <= len;
        pair_cnt <= '0;
      end
      if (take_a) a_hold <= in_data;
      if (issue) begin
        op_a <= a_hold;
        op_b <= in_data;
      end
      // The drain timer restarts on every B word; only the final one leads into DRAIN.
      if (take_b) begin
        pair_cnt <= pair_cnt + LEN_W'(1);
        timer    <= 4'd0;
      end else if (state == DRAIN) begin
        timer <= timer + 4'd1;
      end
      if (zero_start)      result <= 16'h0000;
      else if (drain_done) result <= result_in;
    end
  end

endmodule
